// File: rtl/src_stream_pkg.sv
// Shared types and default widths for the source-stream writer.
package src_stream_pkg;

    localparam int DTW_DWIDTH = 16;
    localparam int AXI_DWIDTH = 32;
    localparam int ADDR_WIDTH = 15;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry ring buffer that absorbs read data already in flight when the
// sink FIFO applies backpressure.
module stream_skid_buf
    import src_stream_pkg::*;
#(
    parameter int width = DTW_DWIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output logic [1:0]       occupancy,
    output logic             nonempty
);

    logic [width-1:0] entries [SKID_DEPTH];
    logic             head_ptr;
    logic             tail_ptr;
    logic [1:0]       count;

    // Pointer and occupancy bookkeeping; push and pop in the same cycle
    // leave the count unchanged while keeping entries in arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                tail_ptr <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_ptr] <= push_data;
        end
    end

    assign head_data = entries[head_ptr];
    assign occupancy = count;
    assign nonempty  = (count != 2'd0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == 2'(SKID_DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == 2'd0)));

endmodule

// File: rtl/src_stream_writer.sv
// Producer side of the dtw_core source FIFO: reads a block of samples from
// a 1-cycle-latency memory and writes them, zero-extended, into the FIFO.
module src_stream_writer
    import src_stream_pkg::*;
#(
    parameter int dtw_dwidth = DTW_DWIDTH,
    parameter int axi_dwidth = AXI_DWIDTH,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [31:0]           stream_len,
    output logic                  running,
    output logic                  done,
    output logic [addr_width-1:0] mem_addr,
    input  logic [dtw_dwidth-1:0] mem_rdata,
    output logic                  sink_fifo_wren,
    input  logic                  sink_fifo_full,
    output logic [axi_dwidth-1:0] sink_fifo_data
);

    state_t                state;
    state_t                state_next;
    logic [addr_width-1:0] addr_q;
    logic [31:0]           remaining;
    logic                  inflight;
    logic                  issue;
    logic                  credit;
    logic                  pop;
    logic [1:0]            occupancy;
    logic                  nonempty;
    logic [dtw_dwidth-1:0] head_data;

    stream_skid_buf #(
        .width(dtw_dwidth)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(mem_rdata),
        .pop      (pop),
        .head_data(head_data),
        .occupancy(occupancy),
        .nonempty (nonempty)
    );

    // Write side: drain the buffer head whenever the FIFO can accept it.
    always_comb begin
        pop            = nonempty & ~sink_fifo_full;
        sink_fifo_wren = pop;
        sink_fifo_data = {{(axi_dwidth - dtw_dwidth){1'b0}}, head_data};
    end

    // Issue credit: buffered words plus the read in flight, less the word
    // leaving this cycle, must stay below the buffer depth.
    always_comb begin
        credit = ((3'(occupancy) + 3'(inflight)) < (3'(SKID_DEPTH) + 3'(pop)));
        issue  = (state == FETCH) && credit && (remaining != 32'd0);
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        running    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (stream_len != 32'd0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                running = 1'b1;
                if (issue && (remaining == 32'd1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                running = 1'b1;
                if (!inflight && !nonempty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, read address, remaining count and in-flight flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            remaining <= 32'd0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if ((state == IDLE) && start && (stream_len != 32'd0)) begin
                addr_q    <= base_addr;
                remaining <= stream_len;
            end else if (issue) begin
                addr_q    <= addr_q + addr_width'(1);
                remaining <= remaining - 32'd1;
            end
        end
    end

    assign mem_addr = addr_q;

endmodule

// File: tb/tb_src_stream_writer.sv
// Self-checking bench for src_stream_writer with a behavioural sample memory.
module tb_src_stream_writer;
    import src_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] base_addr = '0;
    logic [31:0] stream_len = '0;
    logic        running;
    logic        done;
    logic [14:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        sink_fifo_wren;
    logic        sink_fifo_full = 1'b0;
    logic [31:0] sink_fifo_data;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          bp_mode = 0;
    logic [31:0] wr_data [$];
    int          wr_cyc [$];

    typedef struct {
        logic [14:0] base;
        logic [31:0] len;
        int          mode;
        bit          chk_timing;
    } vec_t;

    vec_t vecs [6];

    src_stream_writer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .stream_len    (stream_len),
        .running       (running),
        .done          (done),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .sink_fifo_wren(sink_fifo_wren),
        .sink_fifo_full(sink_fifo_full),
        .sink_fifo_data(sink_fifo_data)
    );

    always #5 clk = ~clk;

    // Sample memory contents: memory[a] = a + 0x100.
    function automatic logic [15:0] mem_val(input logic [14:0] a);
        return {1'b0, a} + 16'h0100;
    endfunction

    // Memory model with one cycle of read latency.
    always @(posedge clk) begin
        mem_rdata <= mem_val(mem_addr);
        cyc       <= cyc + 1;
    end

    // Backpressure generator.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1:       sink_fifo_full = ~sink_fifo_full;
            2:       sink_fifo_full = 1'($urandom_range(0, 1));
            default: sink_fifo_full = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Write and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (sink_fifo_wren) begin
            wr_data.push_back(sink_fifo_data);
            wr_cyc.push_back(cyc);
            checkOutput("no_write_while_full", 64'(sink_fifo_full), 64'd0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            checkOutput("running_low_with_done", 64'(running), 64'd0);
        end
    end

    task automatic applyStimulus(input logic [14:0] base, input logic [31:0] len);
        @(posedge clk);
        #2;
        wr_data.delete();
        wr_cyc.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        base_addr  = base;
        stream_len = len;
        start      = 1'b1;
        @(posedge clk);
        #2;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("done_timeout", 64'(done_cnt == 0), 64'd0);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("done_pulses", 64'(done_cnt), 64'd1);
        checkOutput("running_after_done", 64'(running), 64'd0);
    endtask

    task automatic checkData(input logic [14:0] base, input logic [31:0] len);
        checkOutput("write_count", 64'(wr_data.size()), 64'(len));
        for (int i = 0; i < wr_data.size() && i < int'(len); i++) begin
            checkOutput("write_data", 64'(wr_data[i]), {48'd0, mem_val(15'(base + 15'(i)))});
        end
    endtask

    initial begin
        vecs[0] = '{base: 15'h0000, len: 32'd8,  mode: 0, chk_timing: 1'b1};
        vecs[1] = '{base: 15'h7FFE, len: 32'd4,  mode: 0, chk_timing: 1'b1};
        vecs[2] = '{base: 15'h0123, len: 32'd20, mode: 1, chk_timing: 1'b0};
        vecs[3] = '{base: 15'h0456, len: 32'd20, mode: 2, chk_timing: 1'b0};
        vecs[4] = '{base: 15'h0010, len: 32'd0,  mode: 0, chk_timing: 1'b1};
        vecs[5] = '{base: 15'h7FFF, len: 32'd2,  mode: 0, chk_timing: 1'b1};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_running", 64'(running), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_wren", 64'(sink_fifo_wren), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;

        // Table-driven transfers.
        for (int v = 0; v < 6; v++) begin
            bp_mode = vecs[v].mode;
            applyStimulus(vecs[v].base, vecs[v].len);
            waitDone();
            bp_mode = 0;
            checkData(vecs[v].base, vecs[v].len);
            if (vecs[v].chk_timing) begin
                if (vecs[v].len == 32'd0) begin
                    checkOutput("zero_len_done_cycle", 64'(done_cyc - start_cyc), 64'd0);
                end else if (wr_cyc.size() > 0) begin
                    checkOutput("first_write_latency", 64'(wr_cyc[0] - start_cyc), 64'd2);
                    checkOutput("writes_back_to_back", 64'(wr_cyc[wr_cyc.size()-1] - wr_cyc[0]),
                                64'(vecs[v].len - 32'd1));
                end
            end
        end

        // Reset in the middle of a long transfer.
        begin
            int n = 0;
            int n_before;
            bp_mode = 0;
            applyStimulus(15'h0000, 32'd100);
            while (wr_data.size() < 37 && n < 1000) begin
                @(posedge clk);
                n++;
            end
            checkOutput("reach_write_37", 64'(wr_data.size() >= 37), 64'd1);
            #2;
            rst = 1'b1;
            @(posedge clk);
            #2;
            checkOutput("midreset_running", 64'(running), 64'd0);
            checkOutput("midreset_done", 64'(done), 64'd0);
            checkOutput("midreset_wren", 64'(sink_fifo_wren), 64'd0);
            checkOutput("midreset_mem_addr", 64'(mem_addr), 64'd0);
            rst = 1'b0;
            n_before = wr_data.size();
            repeat (30) @(posedge clk);
            #2;
            checkOutput("midreset_no_more_writes", 64'(wr_data.size()), 64'(n_before));
            checkOutput("midreset_no_done", 64'(done_cnt), 64'd0);
            applyStimulus(15'h0000, 32'd3);
            waitDone();
            checkData(15'h0000, 32'd3);
        end

        // A second start while busy must be ignored.
        applyStimulus(15'h0200, 32'd10);
        repeat (3) @(posedge clk);
        #2;
        base_addr  = 15'h0000;
        stream_len = 32'd5;
        start      = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        waitDone();
        checkData(15'h0200, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
